// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan controller.
package mux_scan_pkg;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCapture
   } scan_state_e;

endpackage

// File: rtl/mux_scan_next_chan.sv
// Priority finder: lowest enabled channel strictly above cur_i (cur_i = -1 finds the first).
module mux_scan_next_chan
   import mux_scan_pkg::*;
(
   input  logic [NCH-1:0]          mask_i,
   input  logic signed [SEL_W:0]   cur_i,
   output logic [SEL_W-1:0]        ch_o,
   output logic                    none_o
);

   always_comb begin
      ch_o   = '0;
      none_o = 1'b1;
      for (int k = 0; k < int'(NCH); k++) begin
         if (none_o && mask_i[k] && (k > int'(cur_i))) begin
            ch_o   = SEL_W'(k);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled channels of a registered 4:1 mux, samples one bit each and
// hands the assembled frame to a valid/ready consumer, once or continuously.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cont,
   input  logic [3:0]         chan_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               mux_out,
   output logic [1:0]         sel,
   output logic [3:0]         frame,
   output logic               frame_valid,
   input  logic               frame_ready,
   output logic               busy,
   output logic               overrun
);

   scan_state_e        state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [NCH-1:0]     mask_q, mask_d;
   logic [NCH-1:0]     buf_q, buf_d;
   logic [NCH-1:0]     frame_q, frame_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               ovr_q, ovr_d;
   logic               done_q, done_d;

   logic [NCH-1:0]     first_mask;
   logic [SEL_W-1:0]   first_ch, next_ch;
   logic               first_none, next_none;

   // In IDLE the first channel comes from the live mask; on a continuous restart from the latch.
   assign first_mask = (state_q == StIdle) ? chan_mask : mask_q;

   mux_scan_next_chan u_first (
      .mask_i (first_mask),
      .cur_i  ({(SEL_W + 1){1'b1}}),
      .ch_o   (first_ch),
      .none_o (first_none)
   );

   mux_scan_next_chan u_next (
      .mask_i (mask_q),
      .cur_i  ({1'b0, sel_q}),
      .ch_o   (next_ch),
      .none_o (next_none)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      mask_d  = mask_q;
      buf_d   = buf_q;
      frame_d = frame_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      ovr_d   = ovr_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !busy_q && !first_none) begin
               mask_d  = chan_mask;
               dwell_d = dwell;
               sel_d   = first_ch;
               cnt_d   = dwell;
               busy_d  = 1'b1;
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StCapture;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StCapture: begin
            buf_d[sel_q] = mux_out;
            if (!next_none) begin
               sel_d   = next_ch;
               cnt_d   = dwell_q;
               state_d = StSettle;
            end else begin
               done_d = 1'b1;
               if (cont) begin
                  sel_d   = first_ch;
                  cnt_d   = dwell_q;
                  state_d = StSettle;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Frame hand-off happens one edge after the last capture closes.
      if (done_q) begin
         if (!valid_q || frame_ready) begin
            frame_d = buf_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
         buf_d = '0;
         if (state_q == StIdle) begin
            busy_d = 1'b0;
         end
      end else if (valid_q && frame_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
         mask_q  <= '0;
         buf_q   <= '0;
         frame_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         mask_q  <= mask_d;
         buf_q   <= buf_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         done_q  <= done_d;
      end
   end

   assign sel         = sel_q;
   assign frame       = frame_q;
   assign frame_valid = valid_q;
   assign busy        = busy_q;
   assign overrun     = ovr_q;

endmodule
